// File: rtl/alu_reservation_station.sv
// Reservation station for ALU-class instructions: holds issued ops until both
// operands arrive (via issue bypass or CDB wakeup), then dispatches one per cycle.
module alu_reservation_station #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_v1,
    input  logic [DATA_W-1:0] issue_v2,
    input  logic [TAG_W-1:0]  issue_q1,
    input  logic [TAG_W-1:0]  issue_q2,
    input  logic              issue_p1,
    input  logic              issue_p2,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_pc,
    input  logic [TAG_W-1:0]  issue_rob_tag,
    output logic              full,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [DATA_W-1:0] pc_to_alu,
    output logic [TAG_W-1:0]  rob_tag_to_alu,
    output logic              is_empty_to_alu
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0]             busy;
    logic [ENTRIES-1:0]             p1;
    logic [ENTRIES-1:0]             p2;
    logic [ENTRIES-1:0][OP_W-1:0]   op_q;
    logic [ENTRIES-1:0][DATA_W-1:0] v1_q;
    logic [ENTRIES-1:0][DATA_W-1:0] v2_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  q1_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  q2_q;
    logic [ENTRIES-1:0][DATA_W-1:0] imm_q;
    logic [ENTRIES-1:0][DATA_W-1:0] pc_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;

    logic [ENTRIES-1:0] ready;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               in_p1;
    logic               in_p2;
    logic [DATA_W-1:0]  in_v1;
    logic [DATA_W-1:0]  in_v2;

    function automatic logic cdb_hit(input logic valid, input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
        return valid && (a == b);
    endfunction

    assign full  = &busy;
    assign ready = busy & ~p1 & ~p2;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Operands still pending at issue can be satisfied by a broadcast in the same cycle.
    always_comb begin
        in_p1 = issue_p1;
        in_v1 = issue_v1;
        in_p2 = issue_p2;
        in_v2 = issue_v2;
        if (issue_p1) begin
            if (cdb_hit(cdb0_valid, cdb0_tag, issue_q1)) begin
                in_p1 = 1'b0;
                in_v1 = cdb0_data;
            end else if (cdb_hit(cdb1_valid, cdb1_tag, issue_q1)) begin
                in_p1 = 1'b0;
                in_v1 = cdb1_data;
            end
        end
        if (issue_p2) begin
            if (cdb_hit(cdb0_valid, cdb0_tag, issue_q2)) begin
                in_p2 = 1'b0;
                in_v2 = cdb0_data;
            end else if (cdb_hit(cdb1_valid, cdb1_tag, issue_q2)) begin
                in_p2 = 1'b0;
                in_v2 = cdb1_data;
            end
        end
    end

    // Issue only targets a free slot and wakeup/dispatch only touch busy ones,
    // so the three updates never collide on the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= '0;
            op_to_alu       <= '0;
            v1_to_alu       <= '0;
            v2_to_alu       <= '0;
            imm_to_alu      <= '0;
            pc_to_alu       <= '0;
            rob_tag_to_alu  <= '0;
            is_empty_to_alu <= 1'b1;
        end else if (rdy) begin
            if (flush) begin
                busy            <= '0;
                is_empty_to_alu <= 1'b1;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (busy[i] && p1[i]) begin
                        if (cdb_hit(cdb0_valid, cdb0_tag, q1_q[i])) begin
                            v1_q[i] <= cdb0_data;
                            p1[i]   <= 1'b0;
                        end else if (cdb_hit(cdb1_valid, cdb1_tag, q1_q[i])) begin
                            v1_q[i] <= cdb1_data;
                            p1[i]   <= 1'b0;
                        end
                    end
                    if (busy[i] && p2[i]) begin
                        if (cdb_hit(cdb0_valid, cdb0_tag, q2_q[i])) begin
                            v2_q[i] <= cdb0_data;
                            p2[i]   <= 1'b0;
                        end else if (cdb_hit(cdb1_valid, cdb1_tag, q2_q[i])) begin
                            v2_q[i] <= cdb1_data;
                            p2[i]   <= 1'b0;
                        end
                    end
                end

                if (sel_valid) begin
                    op_to_alu       <= op_q[sel_idx];
                    v1_to_alu       <= v1_q[sel_idx];
                    v2_to_alu       <= v2_q[sel_idx];
                    imm_to_alu      <= imm_q[sel_idx];
                    pc_to_alu       <= pc_q[sel_idx];
                    rob_tag_to_alu  <= tag_q[sel_idx];
                    is_empty_to_alu <= 1'b0;
                    busy[sel_idx]   <= 1'b0;
                end else begin
                    is_empty_to_alu <= 1'b1;
                end

                if (issue_valid && !full) begin
                    busy[free_idx]  <= 1'b1;
                    op_q[free_idx]  <= issue_op;
                    v1_q[free_idx]  <= in_v1;
                    v2_q[free_idx]  <= in_v2;
                    p1[free_idx]    <= in_p1;
                    p2[free_idx]    <= in_p2;
                    q1_q[free_idx]  <= issue_q1;
                    q2_q[free_idx]  <= issue_q2;
                    imm_q[free_idx] <= issue_imm;
                    pc_q[free_idx]  <= issue_pc;
                    tag_q[free_idx] <= issue_rob_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios followed by random traffic,
// every cycle compared against a slot-list reference model.
module tb_alu_reservation_station;

    localparam int ENTRIES = 16;
    localparam logic [5:0] OP_ADDI = 6'd10;
    localparam logic [5:0] OP_ADD  = 6'd1;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, issue_valid, issue_p1, issue_p2;
    logic [5:0]  issue_op;
    logic [31:0] issue_v1, issue_v2, issue_imm, issue_pc;
    logic [3:0]  issue_q1, issue_q2, issue_rob_tag;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic        full, is_empty_to_alu;
    logic [5:0]  op_to_alu;
    logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
    logic [3:0]  rob_tag_to_alu;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        busy;
        logic        p1;
        logic        p2;
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
    } slot_t;

    slot_t       m [ENTRIES];
    logic        e_empty;
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_tag;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .issue_p1(issue_p1), .issue_p2(issue_p2),
        .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_tag(issue_rob_tag), .full(full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
        .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
        .rob_tag_to_alu(rob_tag_to_alu), .is_empty_to_alu(is_empty_to_alu)
    );

    always #5 clk = ~clk;

    // Returns {still_pending, value}: a pending operand takes CDB0 first, then CDB1.
    function automatic logic [32:0] snoop(input logic p, input logic [3:0] q, input logic [31:0] v);
        if (!p) return {1'b0, v};
        if (cdb0_valid && cdb0_tag == q) return {1'b0, cdb0_data};
        if (cdb1_valid && cdb1_tag == q) return {1'b0, cdb1_data};
        return {1'b1, v};
    endfunction

    function automatic logic model_full();
        int n = 0;
        for (int i = 0; i < ENTRIES; i++) if (m[i].busy) n++;
        return n == ENTRIES;
    endfunction

    function automatic void model_step();
        int d = -1;
        int f = -1;
        logic [32:0] r;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m[i].busy = 1'b0;
            e_empty = 1'b1; e_op = '0; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_tag = '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) m[i].busy = 1'b0;
                e_empty = 1'b1;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (d < 0 && m[i].busy && !m[i].p1 && !m[i].p2) d = i;
                    if (f < 0 && !m[i].busy) f = i;
                end
                if (d >= 0) begin
                    e_empty = 1'b0;
                    e_op = m[d].op; e_v1 = m[d].v1; e_v2 = m[d].v2;
                    e_imm = m[d].imm; e_pc = m[d].pc; e_tag = m[d].tag;
                    m[d].busy = 1'b0;
                end else begin
                    e_empty = 1'b1;
                end
                for (int i = 0; i < ENTRIES; i++) begin
                    if (m[i].busy) begin
                        r = snoop(m[i].p1, m[i].q1, m[i].v1);
                        m[i].p1 = r[32]; m[i].v1 = r[31:0];
                        r = snoop(m[i].p2, m[i].q2, m[i].v2);
                        m[i].p2 = r[32]; m[i].v2 = r[31:0];
                    end
                end
                if (issue_valid && f >= 0) begin
                    m[f].busy = 1'b1;
                    m[f].op = issue_op; m[f].q1 = issue_q1; m[f].q2 = issue_q2;
                    m[f].imm = issue_imm; m[f].pc = issue_pc; m[f].tag = issue_rob_tag;
                    r = snoop(issue_p1, issue_q1, issue_v1);
                    m[f].p1 = r[32]; m[f].v1 = r[31:0];
                    r = snoop(issue_p2, issue_q2, issue_v2);
                    m[f].p2 = r[32]; m[f].v2 = r[31:0];
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("is_empty", 32'(is_empty_to_alu), 32'(e_empty));
        chk("full", 32'(full), 32'(model_full()));
        if (!e_empty) begin
            chk("op", 32'(op_to_alu), 32'(e_op));
            chk("v1", v1_to_alu, e_v1);
            chk("v2", v2_to_alu, e_v2);
            chk("imm", imm_to_alu, e_imm);
            chk("pc", pc_to_alu, e_pc);
            chk("rob_tag", 32'(rob_tag_to_alu), 32'(e_tag));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    task automatic clear_inputs();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_op = '0; issue_v1 = '0; issue_v2 = '0;
        issue_q1 = '0; issue_q2 = '0; issue_p1 = 1'b0; issue_p2 = 1'b0;
        issue_imm = '0; issue_pc = '0; issue_rob_tag = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
    endtask

    task automatic applyStimulus(input logic [5:0] op,
                                 input logic [31:0] v1, input logic p1, input logic [3:0] q1,
                                 input logic [31:0] v2, input logic p2, input logic [3:0] q2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] tag);
        issue_valid = 1'b1; issue_op = op;
        issue_v1 = v1; issue_p1 = p1; issue_q1 = q1;
        issue_v2 = v2; issue_p2 = p2; issue_q2 = q2;
        issue_imm = imm; issue_pc = pc; issue_rob_tag = tag;
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < ENTRIES; i++) m[i] = '0;
        e_empty = 1'b1; e_op = '0; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_tag = '0;

        $display("[TB] reset");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", 32'(is_empty_to_alu), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_op", 32'(op_to_alu), 32'd0);
        chk("rst_v1", v1_to_alu, 32'd0);
        chk("rst_v2", v2_to_alu, 32'd0);
        chk("rst_imm", imm_to_alu, 32'd0);
        chk("rst_pc", pc_to_alu, 32'd0);
        chk("rst_tag", 32'(rob_tag_to_alu), 32'd0);

        $display("[TB] ready issue");
        applyStimulus(OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd3, 32'h100, 4'd2);
        tick();
        clear_inputs();
        chk("ready_not_yet", 32'(is_empty_to_alu), 32'd1);
        tick();
        chk("ready_empty", 32'(is_empty_to_alu), 32'd0);
        chk("ready_op", 32'(op_to_alu), 32'(OP_ADDI));
        chk("ready_v1", v1_to_alu, 32'd5);
        chk("ready_imm", imm_to_alu, 32'd3);
        chk("ready_tag", 32'(rob_tag_to_alu), 32'd2);
        tick();
        chk("ready_after", 32'(is_empty_to_alu), 32'd1);

        $display("[TB] wakeup");
        applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd7, 32'd10, 1'b0, 4'd0, 32'd0, 32'h104, 4'd3);
        tick();
        clear_inputs();
        tick();
        tick();
        cdb1_valid = 1'b1; cdb1_tag = 4'd7; cdb1_data = 32'h20;
        tick();
        clear_inputs();
        chk("wake_not_yet", 32'(is_empty_to_alu), 32'd1);
        tick();
        chk("wake_empty", 32'(is_empty_to_alu), 32'd0);
        chk("wake_v1", v1_to_alu, 32'h20);
        chk("wake_v2", v2_to_alu, 32'd10);

        $display("[TB] issue bypass");
        applyStimulus(OP_ADD, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'd0, 32'h108, 4'd5);
        cdb0_valid = 1'b1; cdb0_tag = 4'd4; cdb0_data = 32'd9;
        tick();
        clear_inputs();
        tick();
        chk("byp_empty", 32'(is_empty_to_alu), 32'd0);
        chk("byp_v2", v2_to_alu, 32'd9);
        chk("byp_tag", 32'(rob_tag_to_alu), 32'd5);

        $display("[TB] full and ordering");
        for (int k = 0; k < ENTRIES; k++) begin
            applyStimulus(OP_ADD, 32'd0, 1'b1, 4'd1, 32'(k), 1'b0, 4'd0, 32'(k), 32'(k * 4), 4'(k));
            tick();
        end
        chk("full_set", 32'(full), 32'd1);
        applyStimulus(OP_ADDI, 32'd77, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'hFFC, 4'd15);
        tick();
        clear_inputs();
        chk("full_drop_full", 32'(full), 32'd1);
        chk("full_drop_empty", 32'(is_empty_to_alu), 32'd1);
        cdb0_valid = 1'b1; cdb0_tag = 4'd1; cdb0_data = 32'h55;
        tick();
        clear_inputs();
        chk("full_bcast", 32'(full), 32'd1);
        for (int k = 0; k < ENTRIES; k++) begin
            tick();
            chk("order_tag", 32'(rob_tag_to_alu), 32'(k));
            chk("order_v1", v1_to_alu, 32'h55);
            if (k == 0) chk("full_clear", 32'(full), 32'd0);
        end
        tick();
        chk("full_drained", 32'(is_empty_to_alu), 32'd1);

        $display("[TB] flush");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(OP_ADDI, 32'(k + 1), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h200, 4'(k + 8));
            tick();
        end
        flush = 1'b1;
        applyStimulus(OP_ADDI, 32'd99, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h300, 4'd12);
        tick();
        clear_inputs();
        chk("flush_empty", 32'(is_empty_to_alu), 32'd1);
        chk("flush_full", 32'(full), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_quiet", 32'(is_empty_to_alu), 32'd1);
        end

        $display("[TB] rdy freeze");
        applyStimulus(OP_ADDI, 32'd42, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 32'h400, 4'd6);
        tick();
        clear_inputs();
        rdy = 1'b0;
        tick();
        tick();
        chk("frozen_empty", 32'(is_empty_to_alu), 32'd1);
        rdy = 1'b1;
        tick();
        chk("thaw_tag", 32'(rob_tag_to_alu), 32'd6);
        tick();
        rdy = 1'b0;
        tick();
        chk("frozen_hold", 32'(is_empty_to_alu), 32'd1);
        clear_inputs();

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            if (rdy) begin
                flush = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 2) != 0)
                    applyStimulus(6'($urandom), $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
                                  $urandom, 1'($urandom), 4'($urandom_range(0, 3)),
                                  $urandom, $urandom, 4'($urandom));
                cdb0_valid = ($urandom_range(0, 3) == 0);
                cdb0_tag = 4'($urandom_range(0, 3));
                cdb0_data = $urandom;
                cdb1_valid = ($urandom_range(0, 3) == 0);
                cdb1_tag = 4'($urandom_range(0, 3));
                cdb1_data = $urandom;
            end
            tick();
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Holds issued ALU-class instructions (LUI/AUIPC/JAL/JALR/branches/arith) until both source operands are available.
- Snoops two common data buses (CDB) to capture operands as they are produced.
- Dispatches one ready instruction per cycle to the combinational ALU through registered outputs.
- Sits between the decoder/issue stage and the ALU; the ALU result goes to the ROB tagged with the dispatched entry's ROB tag.

Parameters:
ENTRIES, 16, number of station slots
TAG_W, 4, ROB tag width
OP_W, 6, internal opcode width (matches ALU op encoding)
DATA_W, 32, operand/immediate/pc width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; 0 freezes all state and outputs
flush  in  1  misprediction clear from ROB
issue_valid  in  1  new instruction present this cycle
issue_op  in  OP_W  opcode
issue_v1 / issue_v2  in  DATA_W  operand values (meaningful when not pending)
issue_q1 / issue_q2  in  TAG_W  producer ROB tags
issue_p1 / issue_p2  in  1  operand pending (1 = wait for tag)
issue_imm  in  DATA_W  immediate
issue_pc  in  DATA_W  instruction pc
issue_rob_tag  in  TAG_W  destination ROB entry
full  out  1  no free slot
cdb0_valid / cdb1_valid  in  1  broadcast valid (0: ALU result, 1: load result)
cdb0_tag / cdb1_tag  in  TAG_W  producing ROB tag
cdb0_data / cdb1_data  in  DATA_W  produced value
op_to_alu  out  OP_W  dispatched opcode
v1_to_alu / v2_to_alu / imm_to_alu / pc_to_alu  out  DATA_W  dispatched fields
rob_tag_to_alu  out  TAG_W  dispatched ROB tag (forwarded with ALU result)
is_empty_to_alu  out  1  1 = no valid dispatch this cycle

Behaviour:
- Reset (rst=1 at posedge): all busy bits cleared; op/v1/v2/imm/pc/rob_tag outputs = 0; is_empty_to_alu = 1; full = 0. rst overrides rdy and flush.
- rdy=0: no state change and outputs held. Issue and CDB inputs in such a cycle are lost; upstream guarantees it does not present them.
- Priority at each posedge: rst > flush > normal operation.
- flush: all busy bits cleared, is_empty_to_alu = 1 next cycle; same-cycle issue and CDB data are discarded.
- full: combinational from registered busy bits, 1 iff all ENTRIES busy. A slot freed by dispatch in the current cycle does not clear full until the next cycle. issue_valid while full is a protocol violation; the instruction is dropped and state is unchanged.
- Issue: the instruction is written to the lowest-index free slot.
  - For each operand with p=1, if either CDB is valid with a matching tag in the same cycle, store the CDB data and p=0 (issue bypass).
  - CDB0 wins if both CDBs match.
- Wakeup: every busy slot with pending operand k compares qk against both CDBs each cycle; on a match it captures the data and clears pk. Both operands may wake in the same cycle.
- Ready = busy & ~p1 & ~p2, evaluated on registered state. An entry written or woken at posedge N is first eligible for selection in the cycle after N.
- Select: the lowest-index ready slot. At posedge, its fields are registered onto the *_to_alu outputs, is_empty_to_alu ← 0, and the slot's busy bit is cleared.
- With no ready slot, is_empty_to_alu ← 1; the other outputs hold their previous values (don't-care).
- Latency: an instruction issued with both operands available appears at the ALU outputs one cycle after its write posedge, i.e. 2 posedges after issue_valid.
- Throughput: at most one issue and one dispatch per cycle. A simultaneous issue and dispatch on the same cycle is legal.
- Operands whose p bit is 0 at issue ignore the CDBs.
- Tag 0 is a valid ROB tag; matching relies on the p bits, never on a reserved tag value.

Test Plan:
- Reset: assert rst 2 cycles → is_empty_to_alu=1, full=0, all ALU outputs 0.
- Ready issue: ADDI, v1=5, imm=3, rob_tag=2, p1=p2=0 → at the 2nd posedge op=ADDI, v1=5, imm=3, rob_tag=2, is_empty=0; is_empty=1 the following cycle.
- Wakeup: ADD with p1=1, q1=7, v2=10. Three cycles later, cdb1 tag=7 data=0x20 → dispatched 2 posedges after the broadcast with v1=0x20, v2=10.
- Issue bypass: ADD with p2=1, q2=4, and cdb0 tag=4 data=9 in the same cycle → dispatched like the ready case with v2=9.
- Full/priority: issue 16 instructions all pending on tag 1 → full=1, and a 17th issue is ignored. Broadcast tag 1 → slots dispatch in order 0..15, one per cycle; full drops the cycle after the first dispatch.
- Flush: 3 ready entries queued, flush asserted with a simultaneous issue → next cycle is_empty=1, full=0, and nothing dispatches afterwards.
